// File: rtl/vga_frame_scheduler.sv
// Per-frame sequencer owning the VGA write port: erase -> logic update -> redraw, one frame per tick.
// vga_* are combinational muxes of the active client; state, counters and status flags are registered.
module vga_frame_scheduler #(
  parameter int TICK_DIV    = 833333,
  parameter int DRAW_CYCLES = 125
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       run,
  output logic       erase_en,
  input  logic       erase_done,
  input  logic [7:0] erase_x,
  input  logic [7:0] erase_y,
  input  logic [2:0] erase_color,
  input  logic       erase_plot,
  output logic       logic_update,
  input  logic       logic_done,
  output logic       draw_reset,
  output logic       draw_en,
  input  logic [7:0] draw_x,
  input  logic [7:0] draw_y,
  input  logic [2:0] draw_color,
  input  logic       draw_plot,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_color,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] frame_count,
  output logic       frame_overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DRAW_LAST = DW'(DRAW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_tick_cnt;
  logic [DW-1:0]   r_draw_cnt;
  logic [7:0]      r_frame_count;
  logic            r_overrun;
  logic            r_logic_update;
  logic            w_tick;
  logic            w_busy;
  logic            w_draw_last;

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_draw_last = (r_draw_cnt == DRAW_LAST);

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b0;
    erase_en    = 1'b0;
    draw_en     = 1'b0;
    draw_reset  = 1'b1;
    vga_x       = 8'd0;
    vga_y       = 8'd0;
    vga_color   = 3'd0;
    vga_plot    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (w_tick)    w_next = S_ERASE;
        else if (!run) w_next = S_IDLE;
      end
      S_ERASE: begin
        w_busy    = 1'b1;
        erase_en  = 1'b1;
        vga_x     = erase_x;
        vga_y     = erase_y;
        vga_color = erase_color;
        vga_plot  = erase_plot;
        if (erase_done) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        w_busy = 1'b1;
        if (logic_done) w_next = S_DRAW;
      end
      S_DRAW: begin
        w_busy     = 1'b1;
        draw_en    = 1'b1;
        draw_reset = 1'b0;
        vga_x      = draw_x;
        vga_y      = draw_y;
        vga_color  = draw_color;
        vga_plot   = draw_plot;
        if (w_draw_last) w_next = S_WAIT_TICK;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_tick_cnt     <= '0;
      r_draw_cnt     <= '0;
      r_frame_count  <= 8'd0;
      r_overrun      <= 1'b0;
      r_logic_update <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      // Held at zero outside DRAW so every pass starts counting from 0.
      r_draw_cnt <= (r_state == S_DRAW) ? r_draw_cnt + 1'b1 : '0;
      if (r_state == S_DRAW && w_draw_last)
        r_frame_count <= r_frame_count + 8'd1;
      if (w_tick && w_busy)
        r_overrun <= 1'b1;
      r_logic_update <= (r_state == S_ERASE) && (w_next == S_UPDATE);
    end
  end

  assign logic_update  = r_logic_update;
  assign busy          = w_busy;
  assign frame_count   = r_frame_count;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Randomised bench for vga_frame_scheduler: a phase/age model of the frame sequence is checked
// against every DUT output each cycle, plus literal checks for the directed scenarios.
module tb_vga_frame_scheduler;

  localparam int TICK_DIV    = 16;
  localparam int DRAW_CYCLES = 8;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_ERASE = 2;
  localparam int P_UPD   = 3;
  localparam int P_DRAW  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       erase_en, erase_done = 1'b0;
  logic [7:0] erase_x = 8'd0, erase_y = 8'd0;
  logic [2:0] erase_color = 3'd0;
  logic       erase_plot = 1'b0;
  logic       logic_update, logic_done = 1'b0;
  logic       draw_reset, draw_en;
  logic [7:0] draw_x = 8'd0, draw_y = 8'd0;
  logic [2:0] draw_color = 3'd0;
  logic       draw_plot = 1'b0;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_color;
  logic       vga_plot, busy, frame_overrun;
  logic [7:0] frame_count;

  vga_frame_scheduler #(.TICK_DIV(TICK_DIV), .DRAW_CYCLES(DRAW_CYCLES)) dut (
    .clock_50(clk), .reset(reset), .run(run),
    .erase_en(erase_en), .erase_done(erase_done),
    .erase_x(erase_x), .erase_y(erase_y), .erase_color(erase_color), .erase_plot(erase_plot),
    .logic_update(logic_update), .logic_done(logic_done),
    .draw_reset(draw_reset), .draw_en(draw_en),
    .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color), .draw_plot(draw_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color), .vga_plot(vga_plot),
    .busy(busy), .frame_count(frame_count), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_fail = 0;
  // Model: current phase, cycles spent in it, cycles since reset, frames done, sticky overrun.
  int m_ph = P_IDLE, m_age = 0, m_since = 0, m_frames = 0;
  bit m_ovr = 0, m_valid = 0;
  // Client responders and monitors.
  int erase_delay = 5, logic_delay = 3, e_age = 0, u_age = 0;
  bit strobe_all = 0;
  int mon_lu = 0, mon_draw = 0, mon_leak = 0, mon_erase_rise = 0, mon_busy = 0;
  bit prev_erase_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit tk;
    int nx;
    if (reset) begin
      m_valid = 1; m_ph = P_IDLE; m_age = 0; m_since = 0; m_frames = 0; m_ovr = 0;
    end else if (m_valid) begin
      tk = (m_since % TICK_DIV) == TICK_DIV - 1;
      m_since++;
      if (tk && m_ph >= P_ERASE) m_ovr = 1;
      nx = m_ph;
      case (m_ph)
        P_IDLE:  if (run) nx = P_WAIT;
        P_WAIT:  if (tk) nx = P_ERASE; else if (!run) nx = P_IDLE;
        P_ERASE: if (erase_done) nx = P_UPD;
        P_UPD:   if (logic_done) nx = P_DRAW;
        default: if (m_age == DRAW_CYCLES - 1) begin
                   nx = P_WAIT;
                   m_frames = (m_frames + 1) % 256;
                 end
      endcase
      m_age = (nx == m_ph) ? m_age + 1 : 0;
      m_ph = nx;
    end
  endtask

  task automatic check_outputs();
    bit er, dr;
    if (!m_valid) return;
    er = (m_ph == P_ERASE);
    dr = (m_ph == P_DRAW);
    chk("erase_en", erase_en, er);
    chk("draw_en", draw_en, dr);
    chk("draw_reset", draw_reset, !dr);
    chk("busy", busy, m_ph >= P_ERASE);
    chk("logic_update", logic_update, (m_ph == P_UPD) && (m_age == 0));
    chk("vga_x", vga_x, er ? erase_x : dr ? draw_x : 8'd0);
    chk("vga_y", vga_y, er ? erase_y : dr ? draw_y : 8'd0);
    chk("vga_color", vga_color, er ? erase_color : dr ? draw_color : 3'd0);
    chk("vga_plot", vga_plot, er ? erase_plot : dr ? draw_plot : 1'b0);
    chk("frame_count", frame_count, m_frames);
    chk("frame_overrun", frame_overrun, m_ovr);
  endtask

  task automatic drive_next();
    if (erase_en) e_age++; else e_age = 0;
    if (busy && !erase_en && !draw_en) u_age++; else u_age = 0;
    erase_done  = erase_en ? (e_age >= erase_delay) : 1'($urandom);
    logic_done  = (u_age > 0) ? (u_age >= logic_delay) : 1'($urandom);
    erase_x     = 8'($urandom);
    erase_y     = 8'($urandom);
    erase_color = 3'($urandom);
    draw_x      = 8'($urandom);
    draw_y      = 8'($urandom);
    draw_color  = 3'($urandom);
    erase_plot  = strobe_all ? 1'b1 : 1'($urandom);
    draw_plot   = strobe_all ? 1'b1 : 1'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    mon_lu   += int'(logic_update);
    mon_draw += int'(draw_en);
    mon_busy += int'(busy);
    mon_leak += int'(vga_plot && !(erase_en || draw_en));
    if (erase_en && !prev_erase_en) mon_erase_rise++;
    prev_erase_en = erase_en;
    drive_next();
  endtask

  task automatic wait_fc(input int target, input int bound, input string nm);
    int n = 0;
    while (frame_count != 8'(target) && n < bound) begin
      step();
      n++;
    end
    chk(nm, frame_count, target);
  endtask

  task automatic wait_draw(input int bound, input string nm);
    int n = 0;
    while (!draw_en && n < bound) begin
      step();
      n++;
    end
    chk(nm, draw_en, 1);
  endtask

  initial begin
    int s_lu, s_draw, s_leak, s_busy, s_rise, k, n;

    // Reset then idle with run low.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    s_busy = mon_busy; s_leak = mon_leak;
    repeat (40) step();
    chk("idle_busy_cycles", mon_busy - s_busy, 0);
    chk("idle_leak_cycles", mon_leak - s_leak, 0);
    chk("idle_frame_count", frame_count, 0);
    chk("idle_draw_reset", draw_reset, 1);

    // Nominal frame with both strobes held high.
    strobe_all = 1; erase_delay = 5; logic_delay = 3;
    s_lu = mon_lu; s_draw = mon_draw; s_leak = mon_leak;
    run = 1'b1;
    wait_fc(1, 100, "nominal_frame_count");
    chk("nominal_update_pulses", mon_lu - s_lu, 1);
    chk("nominal_draw_cycles", mon_draw - s_draw, DRAW_CYCLES);
    chk("nominal_strobe_leak", mon_leak - s_leak, 0);
    strobe_all = 0;

    // Overrun: erase held off for 20 cycles from a fresh reset.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    erase_delay = 20; logic_delay = 2;
    wait_fc(1, 150, "overrun_frame_count");
    chk("overrun_flag", frame_overrun, 1);
    repeat (40) step();
    chk("overrun_sticky", frame_overrun, 1);

    // Reset after three draw cycles.
    erase_delay = 3;
    k = 0; n = 0;
    while (k < 3 && n < 200) begin
      step();
      if (draw_en) k++;
      n++;
    end
    chk("middraw_reached", k, 3);
    reset = 1'b1;
    step();
    chk("middraw_draw_en", draw_en, 0);
    chk("middraw_draw_reset", draw_reset, 1);
    chk("middraw_overrun", frame_overrun, 0);
    chk("middraw_frame_count", frame_count, 0);
    chk("middraw_busy", busy, 0);
    reset = 1'b0;

    // Randomised traffic: run toggles, occasional reset, varying client latency.
    for (int c = 0; c < 1500; c++) begin
      if (c % 30 == 0) begin
        erase_delay = $urandom_range(1, 12);
        logic_delay = $urandom_range(1, 4);
      end
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) run = ~run;
      step();
    end
    reset = 1'b0;

    // 256 fast frames wrap the counter, then stop mid-DRAW.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    run = 1'b1; erase_delay = 1; logic_delay = 1;
    for (int f = 1; f <= 256; f++) wait_fc(f % 256, 40, "wrap_frame_step");
    chk("wrap_frame_count", frame_count, 0);
    chk("wrap_no_overrun", frame_overrun, 0);
    wait_draw(40, "stop_draw_reached");
    run = 1'b0;
    wait_fc(1, 40, "stop_frame_finished");
    s_rise = mon_erase_rise;
    repeat (60) step();
    chk("stop_no_erase", mon_erase_rise - s_rise, 0);
    chk("stop_busy", busy, 0);
    chk("stop_frame_count", frame_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
